// File: rtl/gpio_seq_ctrl.sv
// gpio_seq_ctrl: plays a timed step table (out, ena, hold) onto the GPIO pads, host pass-through when idle.
// Optional build macro GPIO_SEQ_HOLD_LAST_EN: keep the last step on the pads after natural completion.
module gpio_seq_ctrl #(
   parameter int NR_GPIOS  = 3,
   parameter int ADDR_BITS = 3,
   parameter int DUR_BITS  = 16,
   parameter int LOOP_BITS = 8
) (
   input  logic                 clk,
   input  logic                 reset_,
   input  logic                 cfg_wr,
   input  logic [ADDR_BITS-1:0] cfg_addr,
   input  logic [NR_GPIOS-1:0]  cfg_out,
   input  logic [NR_GPIOS-1:0]  cfg_ena,
   input  logic [DUR_BITS-1:0]  cfg_dur,
   input  logic [ADDR_BITS-1:0] seq_last,
   input  logic [LOOP_BITS-1:0] loop_cnt,
   input  logic                 start,
   input  logic                 stop,
   input  logic [NR_GPIOS-1:0]  host_outputs,
   input  logic [NR_GPIOS-1:0]  host_outputs_ena,
   output logic [NR_GPIOS-1:0]  gpio_outputs,
   output logic [NR_GPIOS-1:0]  gpio_outputs_ena,
   output logic                 busy,
   output logic                 done,
   output logic [ADDR_BITS-1:0] step_idx
);
   localparam int DEPTH = 2 ** ADDR_BITS;
`ifdef GPIO_SEQ_HOLD_LAST_EN
   localparam bit HOLD_LAST = 1'b1;
`else
   localparam bit HOLD_LAST = 1'b0;
`endif

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_t;

   state_t               state_q, state_d;
   logic [NR_GPIOS-1:0]  out_q, out_d, ena_q, ena_d;
   logic [ADDR_BITS-1:0] idx_q, idx_d, last_q, last_d, idx_nxt;
   logic [DUR_BITS-1:0]  dur_q, dur_d;
   logic [LOOP_BITS-1:0] loops_q, loops_d, pass_q, pass_d;
   logic [LOOP_BITS:0]   pass_inc;
   logic                 more_passes;
   logic                 hold_q, hold_d;
   logic [NR_GPIOS-1:0]  tbl_out_q [DEPTH];
   logic [NR_GPIOS-1:0]  tbl_out_d [DEPTH];
   logic [NR_GPIOS-1:0]  tbl_ena_q [DEPTH];
   logic [NR_GPIOS-1:0]  tbl_ena_d [DEPTH];
   logic [DUR_BITS-1:0]  tbl_dur_q [DEPTH];
   logic [DUR_BITS-1:0]  tbl_dur_d [DEPTH];

   always_comb begin
      tbl_out_d = tbl_out_q;
      tbl_ena_d = tbl_ena_q;
      tbl_dur_d = tbl_dur_q;
      if (cfg_wr) begin
         tbl_out_d[cfg_addr] = cfg_out;
         tbl_ena_d[cfg_addr] = cfg_ena;
         tbl_dur_d[cfg_addr] = cfg_dur;
      end

      state_d     = state_q;
      out_d       = out_q;
      ena_d       = ena_q;
      idx_d       = idx_q;
      last_d      = last_q;
      dur_d       = dur_q;
      loops_d     = loops_q;
      pass_d      = pass_q;
      hold_d      = hold_q;
      idx_nxt     = idx_q + ADDR_BITS'(1);
      pass_inc    = {1'b0, pass_q} + (LOOP_BITS+1)'(1);
      more_passes = (loops_q == '0) || (pass_inc < {1'b0, loops_q});

      // Loads read the table before this edge's write lands, so a write never alters a held step.
      case (state_q)
         ST_IDLE: begin
            if (stop) begin
               out_d  = host_outputs;
               ena_d  = host_outputs_ena;
               hold_d = 1'b0;
            end else if (start) begin
               state_d = ST_RUN;
               last_d  = seq_last;
               loops_d = loop_cnt;
               pass_d  = '0;
               idx_d   = '0;
               out_d   = tbl_out_q[0];
               ena_d   = tbl_ena_q[0];
               dur_d   = tbl_dur_q[0];
               hold_d  = 1'b0;
            end else if (!hold_q) begin
               out_d = host_outputs;
               ena_d = host_outputs_ena;
            end
         end
         ST_RUN: begin
            if (stop) begin
               state_d = ST_IDLE;
               out_d   = host_outputs;
               ena_d   = host_outputs_ena;
               idx_d   = '0;
               dur_d   = '0;
            end else if (dur_q != '0) begin
               dur_d = dur_q - DUR_BITS'(1);
            end else if (idx_q != last_q) begin
               idx_d = idx_nxt;
               out_d = tbl_out_q[idx_nxt];
               ena_d = tbl_ena_q[idx_nxt];
               dur_d = tbl_dur_q[idx_nxt];
            end else if (more_passes) begin
               pass_d = pass_inc[LOOP_BITS-1:0];
               idx_d  = '0;
               out_d  = tbl_out_q[0];
               ena_d  = tbl_ena_q[0];
               dur_d  = tbl_dur_q[0];
            end else begin
               state_d = ST_DONE;
               idx_d   = '0;
               hold_d  = HOLD_LAST;
               if (!HOLD_LAST) begin
                  out_d = host_outputs;
                  ena_d = host_outputs_ena;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            idx_d   = '0;
            if (!hold_q) begin
               out_d = host_outputs;
               ena_d = host_outputs_ena;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         state_q <= ST_IDLE;
         out_q   <= '0;
         ena_q   <= '0;
         idx_q   <= '0;
         last_q  <= '0;
         dur_q   <= '0;
         loops_q <= '0;
         pass_q  <= '0;
         hold_q  <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            tbl_out_q[i] <= '0;
            tbl_ena_q[i] <= '0;
            tbl_dur_q[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         out_q     <= out_d;
         ena_q     <= ena_d;
         idx_q     <= idx_d;
         last_q    <= last_d;
         dur_q     <= dur_d;
         loops_q   <= loops_d;
         pass_q    <= pass_d;
         hold_q    <= hold_d;
         tbl_out_q <= tbl_out_d;
         tbl_ena_q <= tbl_ena_d;
         tbl_dur_q <= tbl_dur_d;
      end
   end

   assign gpio_outputs     = out_q;
   assign gpio_outputs_ena = ena_q;
   assign busy             = (state_q == ST_RUN);
   assign done             = (state_q == ST_DONE);
   assign step_idx         = idx_q;
endmodule

// File: tb/tb_gpio_seq_ctrl.sv
// Bench for gpio_seq_ctrl: directed scenarios plus random traffic against a step-expansion reference model.
// Build with GPIO_SEQ_HOLD_LAST_EN defined to exercise the hold-last-step variant.
module tb_gpio_seq_ctrl;
   localparam int NG = 3, AB = 3, DB = 16, LB = 8, DEPTH = 8;
`ifdef GPIO_SEQ_HOLD_LAST_EN
   localparam bit HOLD = 1'b1;
`else
   localparam bit HOLD = 1'b0;
`endif

   // ---------------- clock / reset / DUT ----------------
   logic          clk = 1'b0;
   logic          reset_;
   logic          cfg_wr, start, stop;
   logic [AB-1:0] cfg_addr, seq_last, step_idx;
   logic [NG-1:0] cfg_out, cfg_ena, host_outputs, host_outputs_ena;
   logic [NG-1:0] gpio_outputs, gpio_outputs_ena;
   logic [DB-1:0] cfg_dur;
   logic [LB-1:0] loop_cnt;
   logic          busy, done;

   always #5 clk = ~clk;

   gpio_seq_ctrl #(.NR_GPIOS(NG), .ADDR_BITS(AB), .DUR_BITS(DB), .LOOP_BITS(LB)) u_dut (
      .clk(clk), .reset_(reset_), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_out(cfg_out),
      .cfg_ena(cfg_ena), .cfg_dur(cfg_dur), .seq_last(seq_last), .loop_cnt(loop_cnt),
      .start(start), .stop(stop), .host_outputs(host_outputs), .host_outputs_ena(host_outputs_ena),
      .gpio_outputs(gpio_outputs), .gpio_outputs_ena(gpio_outputs_ena), .busy(busy),
      .done(done), .step_idx(step_idx)
   );

   // ---------------- scoreboard ----------------
   int checks = 0;
   int failures = 0;
   int done_seen = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: a loaded step expands into D+1 queued display cycles, popped one per edge.
   logic [8:0]    exp_q[$];
   int            m_mode;            // 0 idle, 1 running, 2 done
   logic [NG-1:0] m_out, m_ena;
   logic [AB-1:0] m_idx;
   bit            m_hold;
   int            m_last, m_loops, m_passes;
   int            t_out[DEPTH], t_ena[DEPTH], t_dur[DEPTH];

   task automatic model_reset();
      m_mode = 0; m_out = '0; m_ena = '0; m_idx = '0; m_hold = 0;
      m_last = 0; m_loops = 0; m_passes = 0;
      exp_q.delete();
      for (int i = 0; i < DEPTH; i++) begin
         t_out[i] = 0; t_ena[i] = 0; t_dur[i] = 0;
      end
   endtask

   task automatic show_front();
      {m_idx, m_out, m_ena} = exp_q[0];
   endtask

   task automatic model_load(input int i);
      for (int k = 0; k <= t_dur[i]; k++)
         exp_q.push_back({3'(i), 3'(t_out[i]), 3'(t_ena[i])});
      show_front();
   endtask

   task automatic show_host();
      m_out = host_outputs;
      m_ena = host_outputs_ena;
   endtask

   task automatic model_step();
      int cur;
      case (m_mode)
         0: begin
            if (stop) begin
               m_hold = 0;
               show_host();
            end else if (start) begin
               m_last = seq_last; m_loops = loop_cnt; m_passes = 0; m_hold = 0;
               exp_q.delete();
               model_load(0);
               m_mode = 1;
            end else if (!m_hold) show_host();
         end
         1: begin
            if (stop) begin
               m_mode = 0; m_idx = '0;
               exp_q.delete();
               show_host();
            end else begin
               cur = m_idx;
               void'(exp_q.pop_front());
               if (exp_q.size() != 0) show_front();
               else if (cur != m_last) model_load(cur + 1);
               else begin
                  m_passes++;
                  if (m_loops == 0 || m_passes < m_loops) model_load(0);
                  else begin
                     m_mode = 2; m_idx = '0; m_hold = HOLD;
                     if (!HOLD) show_host();
                  end
               end
            end
         end
         default: begin
            m_mode = 0; m_idx = '0;
            if (!m_hold) show_host();
         end
      endcase
      if (cfg_wr) begin
         t_out[cfg_addr] = cfg_out; t_ena[cfg_addr] = cfg_ena; t_dur[cfg_addr] = cfg_dur;
      end
   endtask

   task automatic compare_all();
      check_eq("pads", {26'd0, gpio_outputs, gpio_outputs_ena}, {26'd0, m_out, m_ena});
      check_eq("status", {27'd0, busy, done, step_idx},
               {27'd0, (m_mode == 1), (m_mode == 2), m_idx});
   endtask

   // ---------------- driver tasks ----------------
   // Inputs change just after a falling edge; the model consumes them for the next rising edge.
   task automatic tick();
      model_step();
      @(negedge clk);
      if (done) done_seen++;
      compare_all();
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic write_step(input int a, input logic [2:0] o, input logic [2:0] e, input int d);
      cfg_wr = 1'b1; cfg_addr = 3'(a); cfg_out = o; cfg_ena = e; cfg_dur = 16'(d);
      tick();
      cfg_wr = 1'b0;
   endtask

   task automatic pulse_start(input int last, input int loops);
      seq_last = 3'(last); loop_cnt = 8'(loops); start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic pulse_stop();
      stop = 1'b1;
      tick();
      stop = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset_ = 1'b0; cfg_wr = 0; start = 0; stop = 0;
      cfg_addr = '0; cfg_out = '0; cfg_ena = '0; cfg_dur = '0; seq_last = '0; loop_cnt = '0;
      host_outputs = 3'b101; host_outputs_ena = 3'b111;
      model_reset();
      repeat (2) @(negedge clk);
      compare_all();
      reset_ = 1'b1;
      tick();

      // single pass, two steps
      write_step(0, 3'b001, 3'b011, 2);
      write_step(1, 3'b010, 3'b011, 0);
      done_seen = 0;
      pulse_start(1, 1);
      ticks(8);
      check_eq("done_once_l1", done_seen, 1);

      // two passes back to back
      done_seen = 0;
      pulse_start(1, 2);
      ticks(12);
      check_eq("done_once_l2", done_seen, 1);

      // infinite loop aborted by stop
      done_seen = 0;
      pulse_start(1, 0);
      ticks(19);
      pulse_stop();
      ticks(3);
      check_eq("no_done_inf", done_seen, 0);

      // start and stop together in idle
      start = 1'b1; stop = 1'b1;
      tick();
      start = 1'b0; stop = 1'b0;
      tick();

      // rewrite step 0 while it is held; next pass picks it up
      pulse_start(1, 2);
      write_step(0, 3'b111, 3'b011, 2);
      ticks(10);

      // hold-last variant: host changes after completion, then stop in idle
      write_step(0, 3'b001, 3'b011, 2);
      pulse_start(1, 1);
      ticks(6);
      host_outputs = 3'b110; host_outputs_ena = 3'b101;
      ticks(2);
      host_outputs = 3'b101; host_outputs_ena = 3'b111;
      tick();
      pulse_stop();
      ticks(2);

      // single step, zero duration; config changes mid-run are ignored
      write_step(0, 3'b100, 3'b110, 0);
      pulse_start(0, 3);
      seq_last = 3'd5; loop_cnt = 8'd0;
      ticks(5);

      // asynchronous reset in the middle of a run
      write_step(1, 3'b011, 3'b111, 4);
      pulse_start(1, 0);
      ticks(3);
      reset_ = 1'b0;
      #1;
      model_reset();
      compare_all();
      @(negedge clk);
      compare_all();
      reset_ = 1'b1;
      tick();

      // random traffic
      for (int c = 0; c < 1500; c++) begin
         cfg_wr   = ($urandom_range(0, 3) == 0);
         cfg_addr = 3'($urandom_range(0, 7));
         cfg_out  = 3'($urandom_range(0, 7));
         cfg_ena  = 3'($urandom_range(0, 7));
         cfg_dur  = 16'($urandom_range(0, 3));
         seq_last = 3'($urandom_range(0, 7));
         loop_cnt = 8'($urandom_range(0, 3));
         start    = ($urandom_range(0, 9) == 0);
         stop     = ($urandom_range(0, 29) == 0);
         host_outputs     = 3'($urandom_range(0, 7));
         host_outputs_ena = 3'($urandom_range(0, 7));
         tick();
      end
      cfg_wr = 0; start = 0; stop = 0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/gpio_seq_ctrl.md
Name: gpio_seq_ctrl

Overview:
- Timed pattern sequencer for the JTAG-controlled GPIO block, in the system `clk` domain.
- Holds a small step table; each step is an output value, an output-enable mask and a hold duration.
- While idle, it passes the host's static GPIO output/enable values through to the pads.
- While running, it owns the pads and plays the table, optionally looping, then returns control to the host.

Parameters:
- NR_GPIOS, 3, number of GPIO lines driven.
- ADDR_BITS, 3, step-table index width; table depth is 2**ADDR_BITS.
- DUR_BITS, 16, width of the per-step duration field.
- LOOP_BITS, 8, width of the loop counter.

Ports:
- clk  in  1  system clock.
- reset_  in  1  asynchronous active-low reset.
- cfg_wr  in  1  step-table write strobe.
- cfg_addr  in  ADDR_BITS  step index to write.
- cfg_out  in  NR_GPIOS  step output value.
- cfg_ena  in  NR_GPIOS  step output-enable mask.
- cfg_dur  in  DUR_BITS  step duration D; the step is held D+1 cycles.
- seq_last  in  ADDR_BITS  index of the last step played.
- loop_cnt  in  LOOP_BITS  number of passes; 0 means infinite.
- start  in  1  single-cycle start pulse.
- stop  in  1  single-cycle abort pulse.
- host_outputs  in  NR_GPIOS  static output values used when idle.
- host_outputs_ena  in  NR_GPIOS  static output enables used when idle.
- gpio_outputs  out  NR_GPIOS  registered pad output values.
- gpio_outputs_ena  out  NR_GPIOS  registered pad output enables.
- busy  out  1  high in RUN.
- done  out  1  single-cycle pulse on natural completion.
- step_idx  out  ADDR_BITS  index of the step currently driven.

Behaviour:
- Reset (async, reset_=0):
  - State IDLE; gpio_outputs=0, gpio_outputs_ena=0, busy=0, done=0, step_idx=0.
  - Loop and duration counters cleared; all step-table entries cleared to 0.
- Step table:
  - Register array, asynchronous read.
  - cfg_wr writes entry cfg_addr on the clk edge and is accepted in any state.
  - A write to the step currently being held does not change the live outputs; it takes effect the next time that step is loaded.
- States: IDLE, RUN, DONE.
- IDLE:
  - Each edge: gpio_outputs<=host_outputs, gpio_outputs_ena<=host_outputs_ena (1-cycle latency).
  - On start=1 and stop=0 at an edge:
    - Latch seq_last and loop_cnt.
    - step_idx<=0; outputs<=entry[0].out/ena; dur_cnt<=entry[0].dur; pass_cnt<=0.
    - Go to RUN.
  - start and stop in the same cycle: stop wins, stay IDLE.
- RUN (busy=1):
  - If dur_cnt!=0: dur_cnt decrements.
  - Else if step_idx!=latched seq_last: step_idx increments and the next entry loads (outputs and dur_cnt).
  - Else, end of pass:
    - If latched loop_cnt==0, or pass_cnt+1 < latched loop_cnt: pass_cnt increments (wraps freely in infinite mode); step_idx<=0 and entry[0] loads.
    - Otherwise go to DONE.
  - Every step is visible for exactly D+1 cycles. No gap cycle between steps or passes.
- stop in RUN:
  - Next edge goes to IDLE with outputs<=host values; done is not asserted.
  - start in RUN is ignored.
- DONE:
  - Exactly one cycle; done=1; outputs<=host values; step_idx<=0; then IDLE.
  - start in DONE is ignored; stop in DONE has no extra effect.
- Boundaries:
  - seq_last=0 plays a single step.
  - D=0 holds the step 1 cycle.
  - Reset mid-RUN returns asynchronously to the reset values.
  - Changing seq_last or loop_cnt during RUN has no effect until the next start.

Optional Feature:
- Macro: GPIO_SEQ_HOLD_LAST_EN.
- Defined:
  - On natural completion, the outputs keep the last step's out/ena through DONE and IDLE; host values are ignored.
  - The hold persists until the next start, or until a stop pulse arrives in IDLE, which reloads the host values on the following edge.
  - Abort via stop in RUN still reverts to host values immediately.
- Undefined: outputs revert to host values on completion, as specified above.

Test Plan:
- Reset, then host_outputs=3'b101, host_outputs_ena=3'b111 -> outputs 0/0 during reset; 101/111 one cycle after release; busy=0.
- Table {0:out=001,ena=011,D=2; 1:out=010,ena=011,D=0}, seq_last=1, loop_cnt=1, start -> 001 for 3 cycles, 010 for 1 cycle, one-cycle done, then host values.
- Same table, loop_cnt=2 -> pattern 001,001,001,010 repeated twice with no gap; done once, after cycle 8.
- loop_cnt=0, start, stop after 20 cycles -> pattern loops continuously; host values on the next edge after stop; done never asserted.
- start and stop asserted in the same IDLE cycle -> stays IDLE, busy=0. During RUN, cfg_wr to step 0 with out=111 -> current pass unchanged; the next pass shows 111.
- With GPIO_SEQ_HOLD_LAST_EN, loop_cnt=1 -> after done, outputs stay 010/011 while the host drives 101; a stop pulse in IDLE restores 101/111.
